// File: rtl/alu_operand_loader_if.sv
// Board-side bundle for the operand loader: switch/button inputs toward the
// loader and the captured operand set back out to the ALU and LEDs.
interface alu_operand_loader_if #(
  parameter int N   = 4,
  parameter int OPW = 4
);
  logic [N-1:0]   sw_in;
  logic [OPW-1:0] op_in;
  logic           btn_next;
  logic           btn_clear;
  logic [N-1:0]   a_out;
  logic [N-1:0]   b_out;
  logic [OPW-1:0] op_out;
  logic           valid_out;
  logic [1:0]     state_out;

  // Board side: drives switches/buttons, observes the captured set.
  modport master (
    output sw_in, op_in, btn_next, btn_clear,
    input  a_out, b_out, op_out, valid_out, state_out
  );

  // Loader side.
  modport slave (
    input  sw_in, op_in, btn_next, btn_clear,
    output a_out, b_out, op_out, valid_out, state_out
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Steps through A, B and opcode capture on debounced-by-edge button presses
// and presents the completed operand set with a one-cycle valid pulse.
module alu_operand_loader #(
  parameter int N   = 4,
  parameter int OPW = 4
) (
  input logic                clk,
  input logic                rst,
  alu_operand_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    GOT_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  // [0],[1] form the two-flop synchronizer; [2] holds the previous sync value.
  logic [2:0] next_sync;
  logic [2:0] clear_sync;
  logic       next_evt;
  logic       clear_evt;

  state_t         state;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [OPW-1:0] op_q;
  logic           valid_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_sync  <= '0;
      clear_sync <= '0;
    end else begin
      next_sync  <= {next_sync[1:0], bus.btn_next};
      clear_sync <= {clear_sync[1:0], bus.btn_clear};
    end
  end

  // A held button produces a single event: only the low-to-high transition counts.
  assign next_evt  = next_sync[1]  & ~next_sync[2];
  assign clear_evt = clear_sync[1] & ~clear_sync[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clear_evt) begin
        // Clear outranks a coincident next event, which is simply dropped.
        state <= IDLE;
        a_q   <= '0;
        b_q   <= '0;
        op_q  <= '0;
      end else if (next_evt) begin
        case (state)
          IDLE: begin
            a_q   <= bus.sw_in;
            state <= GOT_A;
          end
          GOT_A: begin
            b_q   <= bus.sw_in;
            state <= GOT_B;
          end
          GOT_B: begin
            op_q    <= bus.op_in;
            valid_q <= 1'b1;
            state   <= DONE;
          end
          DONE: begin
            // Restart keeps the old B/opcode visible until they are recaptured.
            a_q   <= bus.sw_in;
            state <= GOT_A;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.op_out    = op_q;
  assign bus.valid_out = valid_q;
  assign bus.state_out = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: a vector table for the press
// sequence plus hand-written held-button, async-reset and restart sequences.
module tb_alu_operand_loader;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   valid_cnt;

  alu_operand_loader_if #(.N(4), .OPW(4)) bus ();

  alu_operand_loader #(.N(4), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // valid_out lives between two rising edges, so one falling-edge sample per pulse.
  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) valid_cnt = valid_cnt + 1;
  end

  typedef struct {
    logic [3:0] sw;
    logic [3:0] op;
    logic       nxt;
    logic       clr;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic [3:0] exp_op;
    logic [1:0] exp_st;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_set(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op, input logic [1:0] st);
    check({tag, " a_out"},     32'(bus.a_out),     32'(a));
    check({tag, " b_out"},     32'(bus.b_out),     32'(b));
    check({tag, " op_out"},    32'(bus.op_out),    32'(op));
    check({tag, " state_out"}, 32'(bus.state_out), 32'(st));
  endtask

  // Hold the buttons for two rising edges, release, then let the pipeline settle.
  task automatic press(input logic [3:0] sw, input logic [3:0] op, input logic nxt, input logic clr);
    @(negedge clk);
    bus.sw_in     = sw;
    bus.op_in     = op;
    bus.btn_next  = nxt;
    bus.btn_clear = clr;
    repeat (2) @(negedge clk);
    bus.btn_next  = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int v0;
    n_checks      = 0;
    n_fail        = 0;
    valid_cnt     = 0;
    rst           = 1'b0;
    bus.sw_in     = '0;
    bus.op_in     = '0;
    bus.btn_next  = 1'b0;
    bus.btn_clear = 1'b0;

    //               sw    op    nxt   clr   a     b     op    st  pulses
    vecs[0] = '{4'hA, 4'h0, 1'b1, 1'b0, 4'hA, 4'h0, 4'h0, 2'd1, 0};
    vecs[1] = '{4'hC, 4'hE, 1'b0, 1'b0, 4'hA, 4'h0, 4'h0, 2'd1, 0};
    vecs[2] = '{4'h3, 4'h0, 1'b1, 1'b0, 4'hA, 4'h3, 4'h0, 2'd2, 0};
    vecs[3] = '{4'h0, 4'h5, 1'b1, 1'b0, 4'hA, 4'h3, 4'h5, 2'd3, 1};
    vecs[4] = '{4'hF, 4'h1, 1'b1, 1'b0, 4'hF, 4'h3, 4'h5, 2'd1, 0};
    vecs[5] = '{4'h9, 4'h2, 1'b1, 1'b0, 4'hF, 4'h9, 4'h5, 2'd2, 0};
    vecs[6] = '{4'h4, 4'h4, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 2'd0, 0};
    vecs[7] = '{4'h7, 4'h6, 1'b1, 1'b0, 4'h7, 4'h0, 4'h0, 2'd1, 0};
    vecs[8] = '{4'h8, 4'h9, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 2'd0, 0};

    // Asynchronous reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #2;
    check_set("reset", 4'h0, 4'h0, 4'h0, 2'd0);
    check("reset valid_out", 32'(bus.valid_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      v0 = valid_cnt;
      press(vecs[i].sw, vecs[i].op, vecs[i].nxt, vecs[i].clr);
      check_set($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_op, vecs[i].exp_st);
      check($sformatf("vec%0d valid pulses", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_pulses));
    end

    // Held button from IDLE: capture on the third rising edge, then nothing more.
    @(negedge clk);
    bus.sw_in    = 4'h6;
    bus.btn_next = 1'b1;
    @(posedge clk); #1;
    check("held edge1 state", 32'(bus.state_out), 32'd0);
    @(posedge clk); #1;
    check("held edge2 state", 32'(bus.state_out), 32'd0);
    check("held edge2 a_out", 32'(bus.a_out), 32'h0);
    @(posedge clk); #1;
    check("held edge3 state", 32'(bus.state_out), 32'd1);
    check("held edge3 a_out", 32'(bus.a_out), 32'h6);
    repeat (17) @(negedge clk);
    check_set("held 20 cycles", 4'h6, 4'h0, 4'h0, 2'd1);
    bus.btn_next = 1'b0;
    repeat (4) @(negedge clk);
    check("held release state", 32'(bus.state_out), 32'd1);

    // Async reset while in DONE, then a complete sequence afterwards.
    press(4'h4, 4'h0, 1'b1, 1'b0);
    v0 = valid_cnt;
    press(4'h0, 4'h8, 1'b1, 1'b0);
    check_set("pre-reset done", 4'h6, 4'h4, 4'h8, 2'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_set("async reset in DONE", 4'h0, 4'h0, 4'h0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    press(4'hA, 4'h0, 1'b1, 1'b0);
    press(4'h3, 4'h0, 1'b1, 1'b0);
    press(4'h0, 4'h5, 1'b1, 1'b0);
    check_set("post-reset sequence", 4'hA, 4'h3, 4'h5, 2'd3);
    check("post-reset valid pulses", 32'(valid_cnt - v0), 32'd2);

    // Reset while in GOT_B discards the partial set with no valid pulse.
    press(4'h2, 4'h0, 1'b1, 1'b0);
    press(4'h1, 4'h0, 1'b1, 1'b0);
    check("pre-reset GOT_B", 32'(bus.state_out), 32'd2);
    v0 = valid_cnt;
    @(negedge clk);
    rst = 1'b1;
    // Button already high when reset is released yields exactly one event.
    bus.sw_in    = 4'hB;
    bus.btn_next = 1'b1;
    repeat (2) @(negedge clk);
    check_set("reset in GOT_B", 4'h0, 4'h0, 4'h0, 2'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    bus.btn_next = 1'b0;
    repeat (4) @(negedge clk);
    check_set("held through reset", 4'hB, 4'h0, 4'h0, 2'd1);
    check("no pulse after reset", 32'(valid_cnt - v0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
